demux2_4b_buf: RTL and testbench
================================

# demux2_4b_buf

Two-lane 4-bit demultiplexing receiver with per-lane buffering. It sits at the far end of a shared 4-bit link where a 2:1 4-bit mux time-multiplexes two producer lanes. Each transfer arrives with its lane select, is steered into that lane's 2-entry FIFO, and is delivered on a per-lane valid/ready output. Per-lane 8-bit delivery counters support link bring-up and debug.

## Interface

- Parameters: none. FIFO depth is fixed at 2 entries per lane; counter width is fixed at 8 bits.
- Clock and reset:
  - Single clock `clk`; all state updates on its rising edge.
  - Reset `rst` is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_val  in  1  input transfer valid
- in_rdy  out  1  input accepted when in_val & in_rdy
- in_sel  in  1  destination lane (0 → lane 0, 1 → lane 1); meaningful only while in_val=1
- in_data  in  4  input payload
- out0_val  out  1  lane 0 head valid
- out0_rdy  in  1  lane 0 consumer ready
- out0_data  out  4  lane 0 head payload
- out1_val  out  1  lane 1 head valid
- out1_rdy  in  1  lane 1 consumer ready
- out1_data  out  4  lane 1 head payload
- count0  out  8  lane 0 deliveries, mod 256
- count1  out  8  lane 1 deliveries, mod 256

## Operation

- Each lane L has a 2-entry FIFO with occupancy occL ∈ {0,1,2}, a head pointer and a tail pointer.
- Flow control:
  - in_rdy = (in_sel ? occ1 : occ0) != 2. It is combinational on in_sel and does not depend on in_val.
  - A full lane accepts nothing, even if its head dequeues in the same cycle (no pass-through when full).
- Enqueue: on in_val & in_rdy, in_data is written at lane in_sel's tail.
- Dequeue:
  - outL_val = (occL != 0); outL_data = entry at lane L's head.
  - On outL_val & outL_rdy the head advances and countL increments, wrapping 255 → 0.
- Simultaneous enqueue and dequeue on the same lane:
  - occL is unchanged.
  - FIFO order is preserved; at occL=1 the old entry leaves and the new one becomes the head.
- Lanes are fully independent:
  - Lane 1 full never blocks a lane 0 transfer.
  - Both lanes may dequeue in the same cycle.
- No drops, no reordering within a lane, and no data on a lane other than its in_sel.
- outL_data while outL_val=0 is don't-care for consumers. After reset it reads 4'h0 (storage is cleared on reset).

## Timing

- Reset (asynchronous; takes effect immediately, without waiting for a clock edge):
  - occ0 = occ1 = 0, all pointers 0, storage 0, count0 = count1 = 0.
  - Resulting outputs: out0_val = out1_val = 0, out0_data = out1_data = 0, count0 = count1 = 0.
  - in_rdy = 1 during and after reset.
- Latency: a word accepted at edge k shows outL_val=1 with that data after edge k. Minimum in→out latency is 1 cycle; there is no combinational in→out path.
- Throughput: 1 word/cycle per lane in steady state when the consumer holds outL_rdy=1. Depth 2 sustains this without bubbles.
- Counters update at the same edge as the dequeue.
- Reset mid-operation: all buffered words are discarded, with no delivery and no count. Operation resumes on the first edge after rst deasserts.
- Inputs are sampled only at rising edges; in_sel and in_data may change freely between transfers.

## Test plan

- Reset and idle:
  - Stimulus: assert rst mid-cycle with occ0=2.
  - Response: out0_val drops before the next edge; count0=0, in_rdy=1, all data outputs 0.
- Steering:
  - Stimulus: send (sel=0,4'hA), (sel=1,4'h5), (sel=0,4'h3) back-to-back with both outL_rdy=1.
  - Response: lane 0 delivers A then 3, lane 1 delivers 5; count0=2, count1=1.
- Full and backpressure:
  - Stimulus: out0_rdy=0; send 4'h1, 4'h2, 4'h3 to lane 0.
  - Response: the third transfer sees in_rdy=0 and is held. Raising out0_rdy delivers 1, 2, 3 in order, with in_rdy=0 in the full cycle even while a dequeue occurs.
- Independence:
  - Stimulus: fill lane 1 (out1_rdy=0), then send 4'hC on sel=0.
  - Response: accepted in 1 cycle; out0_data=C the next cycle; lane 1 contents unchanged.
- Simultaneous enqueue/dequeue at occ=1:
  - Stimulus: lane 0 holds 4'h7; enqueue 4'h8 while out0_rdy=1.
  - Response: 7 delivered this cycle, out0_data=8 next cycle, occ0 stays 1.
- Counter wrap:
  - Stimulus: 257 lane 1 deliveries.
  - Response: count1 reads 255 after the 255th, 0 after the 256th, 1 after the 257th.

Source files
------------

// File: rtl/demux2_4b_buf.sv
// Two-lane 4-bit demux receiver: each accepted word is steered by in_sel into a 2-entry per-lane FIFO.
// Latency 1 cycle in->out. Backpressure: in_rdy drops while the selected lane is full, with no pass-through.
module demux2_4b_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic       in_sel,
  input  logic [3:0] in_data,
  output logic       out0_val,
  input  logic       out0_rdy,
  output logic [3:0] out0_data,
  output logic       out1_val,
  input  logic       out1_rdy,
  output logic [3:0] out1_data,
  output logic [7:0] count0,
  output logic [7:0] count1
);

  logic [3:0] r_mem [2][2];
  logic [1:0] r_occ [2];
  logic [7:0] r_cnt [2];
  logic [1:0] r_head;
  logic [1:0] r_tail;

  logic [1:0] w_full;
  logic [1:0] w_rdy;
  logic [1:0] w_enq;
  logic [1:0] w_deq;

  assign w_rdy = {out1_rdy, out0_rdy};

  // Readiness looks only at occupancy, so a full lane stays closed even while it drains.
  always_comb begin
    w_full = '0;
    w_enq  = '0;
    w_deq  = '0;
    for (int l = 0; l < 2; l++) begin
      w_full[l] = (r_occ[l] == 2'd2);
      w_deq[l]  = (r_occ[l] != 2'd0) && w_rdy[l];
    end
    in_rdy = in_sel ? !w_full[1] : !w_full[0];
    for (int l = 0; l < 2; l++) begin
      w_enq[l] = in_val && in_rdy && (in_sel == l[0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        r_mem[l][0] <= 4'h0;
        r_mem[l][1] <= 4'h0;
        r_occ[l]    <= 2'd0;
        r_cnt[l]    <= 8'd0;
      end
      r_head <= 2'b00;
      r_tail <= 2'b00;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (w_enq[l]) begin
          r_mem[l][r_tail[l]] <= in_data;
          r_tail[l]           <= ~r_tail[l];
        end
        if (w_deq[l]) begin
          r_head[l] <= ~r_head[l];
          r_cnt[l]  <= r_cnt[l] + 8'd1;
        end
        case ({w_enq[l], w_deq[l]})
          2'b10:   r_occ[l] <= r_occ[l] + 2'd1;
          2'b01:   r_occ[l] <= r_occ[l] - 2'd1;
          default: r_occ[l] <= r_occ[l];
        endcase
      end
    end
  end

  assign out0_val  = (r_occ[0] != 2'd0);
  assign out1_val  = (r_occ[1] != 2'd0);
  assign out0_data = r_mem[0][r_head[0]];
  assign out1_data = r_mem[1][r_head[1]];
  assign count0    = r_cnt[0];
  assign count1    = r_cnt[1];

endmodule

// File: tb/tb_demux2_4b_buf.sv
// Directed bench for demux2_4b_buf: steering, backpressure, lane independence, reset and counter wrap.
module tb_demux2_4b_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_val, in_sel, in_rdy;
  logic [3:0] in_data;
  logic       out0_val, out0_rdy, out1_val, out1_rdy;
  logic [3:0] out0_data, out1_data;
  logic [7:0] count0, count1;

  int checks = 0;
  int errors = 0;

  demux2_4b_buf dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_sel(in_sel), .in_data(in_data),
    .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_data(out0_data),
    .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_data(out1_data),
    .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_val = 1'b0; in_sel = 1'b0; in_data = 4'h0;
    out0_rdy = 1'b0; out1_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0_val", 8'(out0_val), 8'd0);
    chk("rst_out1_val", 8'(out1_val), 8'd0);
    chk("rst_in_rdy", 8'(in_rdy), 8'd1);
    chk("rst_out0_data", 8'(out0_data), 8'h0);
    chk("rst_count0", count0, 8'd0);
    rst = 1'b0;
    tick();

    // Steering: A->lane0, 5->lane1, 3->lane0, consumers always ready.
    out0_rdy = 1'b1; out1_rdy = 1'b1;
    in_val = 1'b1; in_sel = 1'b0; in_data = 4'hA; #1;
    chk("steer_in_rdy", 8'(in_rdy), 8'd1);
    tick();
    in_sel = 1'b1; in_data = 4'h5; #1;
    chk("steer_out0_val_A", 8'(out0_val), 8'd1);
    chk("steer_out0_data_A", 8'(out0_data), 8'hA);
    chk("steer_out1_val_idle", 8'(out1_val), 8'd0);
    tick();
    in_sel = 1'b0; in_data = 4'h3; #1;
    chk("steer_out1_data_5", 8'(out1_data), 8'h5);
    chk("steer_out0_val_gap", 8'(out0_val), 8'd0);
    chk("steer_count0_1", count0, 8'd1);
    tick();
    in_val = 1'b0; #1;
    chk("steer_out0_data_3", 8'(out0_data), 8'h3);
    chk("steer_count1_1", count1, 8'd1);
    tick();
    chk("steer_count0_2", count0, 8'd2);
    chk("steer_idle0", 8'(out0_val), 8'd0);
    chk("steer_idle1", 8'(out1_val), 8'd0);

    // Full lane 0 and backpressure.
    out0_rdy = 1'b0;
    in_val = 1'b1; in_sel = 1'b0; in_data = 4'h1; tick();
    in_data = 4'h2; tick();
    in_data = 4'h3; #1;
    chk("full_in_rdy0", 8'(in_rdy), 8'd0);
    chk("full_head1", 8'(out0_data), 8'h1);
    tick();
    chk("full_held_in_rdy0", 8'(in_rdy), 8'd0);
    out0_rdy = 1'b1; #1;
    chk("full_no_passthru", 8'(in_rdy), 8'd0);
    tick();
    chk("full_drain_in_rdy1", 8'(in_rdy), 8'd1);
    chk("full_head2", 8'(out0_data), 8'h2);
    tick();
    in_val = 1'b0; #1;
    chk("full_head3", 8'(out0_data), 8'h3);
    chk("full_val3", 8'(out0_val), 8'd1);
    tick();
    chk("full_empty", 8'(out0_val), 8'd0);
    chk("full_count0_5", count0, 8'd5);

    // Independence: lane 1 full does not block lane 0.
    out0_rdy = 1'b0; out1_rdy = 1'b0;
    in_val = 1'b1; in_sel = 1'b1; in_data = 4'h9; tick();
    in_data = 4'h6; tick();
    chk("ind_lane1_full", 8'(in_rdy), 8'd0);
    in_sel = 1'b0; in_data = 4'hC; #1;
    chk("ind_lane0_rdy", 8'(in_rdy), 8'd1);
    tick();
    in_val = 1'b0; #1;
    chk("ind_out0_C", 8'(out0_data), 8'hC);
    chk("ind_out1_9", 8'(out1_data), 8'h9);
    chk("ind_count1", count1, 8'd1);
    out0_rdy = 1'b1; out1_rdy = 1'b1; tick();
    chk("ind_count0_6", count0, 8'd6);
    chk("ind_both_deq_count1", count1, 8'd2);
    chk("ind_out1_6", 8'(out1_data), 8'h6);
    out0_rdy = 1'b0; tick();
    chk("ind_count1_3", count1, 8'd3);
    chk("ind_out1_empty", 8'(out1_val), 8'd0);
    out1_rdy = 1'b0;

    // Simultaneous enqueue/dequeue at occupancy 1.
    in_val = 1'b1; in_sel = 1'b0; in_data = 4'h7; tick();
    in_data = 4'h8; out0_rdy = 1'b1; #1;
    chk("sim_head7", 8'(out0_data), 8'h7);
    chk("sim_in_rdy", 8'(in_rdy), 8'd1);
    tick();
    in_val = 1'b0; out0_rdy = 1'b0; #1;
    chk("sim_head8", 8'(out0_data), 8'h8);
    chk("sim_val8", 8'(out0_val), 8'd1);
    chk("sim_count0_7", count0, 8'd7);
    out0_rdy = 1'b1; tick();
    chk("sim_occ_was1", 8'(out0_val), 8'd0);
    chk("sim_count0_8", count0, 8'd8);

    // Asynchronous reset mid-cycle with lane 0 full.
    out0_rdy = 1'b0;
    in_val = 1'b1; in_sel = 1'b0; in_data = 4'hE; tick();
    in_data = 4'hF; tick();
    in_val = 1'b0; #1;
    chk("pre_rst_full", 8'(in_rdy), 8'd0);
    #1 rst = 1'b1; #1;
    chk("arst_out0_val", 8'(out0_val), 8'd0);
    chk("arst_count0", count0, 8'd0);
    chk("arst_count1", count1, 8'd0);
    chk("arst_in_rdy", 8'(in_rdy), 8'd1);
    chk("arst_out0_data", 8'(out0_data), 8'h0);
    chk("arst_out1_data", 8'(out1_data), 8'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_empty", 8'(out0_val), 8'd0);

    // Counter wrap on lane 1.
    out1_rdy = 1'b1; in_val = 1'b1; in_sel = 1'b1;
    in_data = 4'h0;
    tick();
    for (int k = 1; k <= 257; k++) begin
      in_data = 4'(k);
      tick();
      if (k == 255) chk("wrap_255", count1, 8'd255);
      if (k == 256) chk("wrap_256", count1, 8'd0);
      if (k == 257) chk("wrap_257", count1, 8'd1);
    end
    in_val = 1'b0;
    chk("wrap_count0_quiet", count0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
